// File: rtl/bfp_dot_accum.sv
`default_nettype none
// ============================================================================
// Module   : bfp_dot_accum
// Function : Exact BFP dot product (multiply / adder tree / accumulate) with
//            combined block exponent; feeds the BFP-to-FP converter.
// Revision : 1.0
// ============================================================================
module bfp_dot_accum #(
  parameter int V    = 16,
  parameter int P    = 4,
  parameter int BIT  = 16,
  parameter int FPM  = 10,
  parameter int BFPM = 5
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  input  logic [P*(BFPM+2)-1:0]                in_a,
  input  logic [P*(BFPM+2)-1:0]                in_b,
  input  logic [BIT-FPM-2:0]                   in_exp_a,
  input  logic [BIT-FPM-2:0]                   in_exp_b,
  output logic [2*(BFPM+2)+$clog2(V)-1:0]      out_val,
  output logic [BIT-FPM-2:0]                   out_exp,
  output logic                                 out_rdy,
  output logic                                 busy
);

  localparam int c_E     = BIT - FPM - 1;
  localparam int c_B     = 2**(c_E-1) - 1;
  localparam int c_N     = BFPM + 2;
  localparam int c_W     = 2*c_N + $clog2(V);
  localparam int c_BEATS = V / P;
  localparam int c_CW    = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;

  localparam logic [c_CW-1:0]       c_LAST_BEAT = c_CW'(c_BEATS - 1);
  localparam logic signed [c_E+1:0] c_BIAS      = (c_E+2)'(c_B);
  localparam logic signed [c_E+1:0] c_EMAX      = (c_E+2)'(2**c_E - 1);

  logic [c_CW-1:0]            r_beat;
  logic                       r_s1_vld;
  logic                       r_s1_first;
  logic                       r_s1_last;
  logic signed [c_E+1:0]      r_exp_sum;
  logic signed [2*c_N-1:0]    r_prod [P];
  logic signed [c_W-1:0]      r_acc;

  logic                       w_first;
  logic                       w_last;
  logic signed [c_E+1:0]      w_exp_sum;
  logic signed [2*c_N-1:0]    w_prod [P];
  logic signed [c_W-1:0]      w_tree;
  logic signed [c_W-1:0]      w_acc_next;
  logic [c_E-1:0]             w_exp_sat;

  assign w_first   = (r_beat == '0);
  assign w_last    = (r_beat == c_LAST_BEAT);
  assign busy      = (r_beat != '0);
  assign w_exp_sum = $signed({2'b00, in_exp_a}) + $signed({2'b00, in_exp_b}) - c_BIAS;

  generate
    for (genvar gi = 0; gi < P; gi++) begin : g_lane
      assign w_prod[gi] = $signed(in_a[gi*c_N +: c_N]) * $signed(in_b[gi*c_N +: c_N]);
    end
  endgenerate

  // Stage 1: products, beat position flags and (first beat only) exponent sum
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat     <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_exp_sum  <= '0;
      for (int i = 0; i < P; i++) r_prod[i] <= '0;
    end else begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_beat     <= w_last ? '0 : r_beat + 1'b1;
        r_s1_first <= w_first;
        r_s1_last  <= w_last;
        for (int i = 0; i < P; i++) r_prod[i] <= w_prod[i];
        if (w_first) r_exp_sum <= w_exp_sum;
      end
    end
  end

  always_comb begin
    w_tree = '0;
    for (int i = 0; i < P; i++) begin
      w_tree = w_tree + {{(c_W-2*c_N){r_prod[i][2*c_N-1]}}, r_prod[i]};
    end
  end

  // First beat loads instead of adding, so consecutive vectors need no clear cycle
  assign w_acc_next = r_s1_first ? w_tree : r_acc + w_tree;

  always_comb begin
    w_exp_sat = r_exp_sum[c_E-1:0];
    if (r_exp_sum < 0) begin
      w_exp_sat = '0;
    end else if (r_exp_sum > c_EMAX) begin
      w_exp_sat = '1;
    end
  end

  // Stage 2: accumulate and publish on the last beat
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc   <= '0;
      out_val <= '0;
      out_exp <= '0;
      out_rdy <= 1'b0;
    end else begin
      out_rdy <= 1'b0;
      if (r_s1_vld) begin
        r_acc <= w_acc_next;
        if (r_s1_last) begin
          out_val <= w_acc_next;
          out_exp <= w_exp_sat;
          out_rdy <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
